// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if -- bus between the EX stage, the MEM/WB stage and the
// register file / forwarding unit.
//   ex_*            : instruction leaving EX (driven by master)
//   wb_*            : register-file write port (driven by slave)
//   mem_fwd_*       : MEM-stage result for the forwarding unit (slave)
//   misalign_err    : sticky misaligned-access flag (slave)
interface mem_wb_stage_if;
    logic        ex_valid;
    logic [15:0] ex_alu_result;
    logic [15:0] ex_store_data;
    logic [1:0]  ex_wr;
    logic        ex_regwrite;
    logic        ex_memtoreg;
    logic        ex_memwrite;

    logic [15:0] wb_wd;
    logic [1:0]  wb_wr;
    logic        wb_regwrite;
    logic        mem_fwd_regwrite;
    logic [1:0]  mem_fwd_wr;
    logic [15:0] mem_fwd_data;
    logic        misalign_err;

    modport master (
        output ex_valid, ex_alu_result, ex_store_data, ex_wr,
               ex_regwrite, ex_memtoreg, ex_memwrite,
        input  wb_wd, wb_wr, wb_regwrite,
               mem_fwd_regwrite, mem_fwd_wr, mem_fwd_data, misalign_err
    );

    modport slave (
        input  ex_valid, ex_alu_result, ex_store_data, ex_wr,
               ex_regwrite, ex_memtoreg, ex_memwrite,
        output wb_wd, wb_wr, wb_regwrite,
               mem_fwd_regwrite, mem_fwd_wr, mem_fwd_data, misalign_err
    );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage -- EX/MEM register, 256 x 16 data memory, MEM/WB register.
// Ports:
//   clk   : stage clock, all registers update on its falling edge
//   rst_n : asynchronous active-low reset (memory contents are kept)
//   bus   : mem_wb_stage_if.slave (ex_* in; wb_*, mem_fwd_*, misalign_err out)
// Build option: define MEM_WB_FWD_EN to drive the mem_fwd_* outputs from
// EX/MEM; otherwise they are tied to 0.
module mem_wb_stage (
    input  logic           clk,
    input  logic           rst_n,
    mem_wb_stage_if.slave  bus
);
    typedef struct packed {
        logic        valid;
        logic [15:0] alu_result;
        logic [15:0] store_data;
        logic [1:0]  wr;
        logic        regwrite;
        logic        memtoreg;
        logic        memwrite;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] wd;
        logic [1:0]  wr;
        logic        regwrite;
    } mem_wb_t;

    ex_mem_t     em;
    mem_wb_t     mw;
    logic        err_q;
    logic [15:0] dmem [256];

    logic [7:0]  idx;
    logic [15:0] rd_data;
    logic        misaligned;
    logic        ld_bad;
    logic        mem_we;

    // Byte address -> word index; bits [15:9] are dropped so addresses wrap.
    assign idx        = em.alu_result[8:1];
    assign rd_data    = dmem[idx];
    assign misaligned = em.valid & (em.memtoreg | em.memwrite) & em.alu_result[0];
    assign ld_bad     = em.valid & em.memtoreg & em.alu_result[0];
    assign mem_we     = em.valid & em.memwrite & ~em.alu_result[0];

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            em    <= '0;
            mw    <= '0;
            err_q <= 1'b0;
        end else begin
            em <= '{valid:      bus.ex_valid,
                    alu_result: bus.ex_alu_result,
                    store_data: bus.ex_store_data,
                    wr:         bus.ex_wr,
                    regwrite:   bus.ex_regwrite,
                    memtoreg:   bus.ex_memtoreg,
                    memwrite:   bus.ex_memwrite};
            mw.valid    <= em.valid;
            mw.wd       <= em.memtoreg ? rd_data : em.alu_result;
            mw.wr       <= em.wr;
            // $0 is hardwired, so a write to it is never enabled.
            mw.regwrite <= em.regwrite & em.valid & ~ld_bad & (em.wr != 2'd0);
            if (misaligned)
                err_q <= 1'b1;
        end
    end

    // No reset on the array: contents survive reset. A store still sitting
    // in EX/MEM when reset hits is dropped because em.valid clears at once.
    always_ff @(negedge clk) begin
        if (mem_we)
            dmem[idx] <= em.store_data;
    end

    assign bus.wb_wd        = mw.wd;
    assign bus.wb_wr        = mw.wr;
    assign bus.wb_regwrite  = mw.valid & mw.regwrite;
    assign bus.misalign_err = err_q;

`ifdef MEM_WB_FWD_EN
    assign bus.mem_fwd_regwrite = em.regwrite & em.valid & (em.wr != 2'd0);
    assign bus.mem_fwd_wr       = em.wr;
    assign bus.mem_fwd_data     = em.alu_result;
`else
    assign bus.mem_fwd_regwrite = 1'b0;
    assign bus.mem_fwd_wr       = 2'd0;
    assign bus.mem_fwd_data     = 16'd0;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage -- directed bench for mem_wb_stage. An instruction-level
// model retires each instruction in program order one falling edge after it
// is accepted; a compare process checks every output against it on each
// rising edge, and the main sequence pins the model with literal checks.
module tb_mem_wb_stage;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_wb_stage_if bus();

    mem_wb_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic        v;
        logic [15:0] alu;
        logic [15:0] sd;
        logic [1:0]  wr;
        logic        rw;
        logic        mtr;
        logic        mw;
    } ins_t;

    ins_t        pend;
    logic [15:0] mmem [256];
    bit          mknown [256];
    logic [15:0] exp_wd;
    logic [1:0]  exp_wr;
    logic        exp_rw;
    logic        exp_wd_known;
    logic        exp_err;

    initial begin
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                pend         = '{default: '0};
                exp_wd       = '0;
                exp_wr       = '0;
                exp_rw       = 1'b0;
                exp_wd_known = 1'b1;
                exp_err      = 1'b0;
            end else begin
                int  a;
                bit  odd;
                a   = int'(pend.alu) % 512 / 2;
                odd = pend.alu[0];
                if (pend.v && pend.mw && !odd) begin
                    mmem[a]   = pend.sd;
                    mknown[a] = 1'b1;
                end
                exp_wd       = pend.mtr ? mmem[a] : pend.alu;
                exp_wd_known = !pend.mtr || mknown[a];
                exp_wr       = pend.wr;
                exp_rw       = pend.v && pend.rw && (pend.wr != 2'd0) && !(pend.mtr && odd);
                if (pend.v && (pend.mtr || pend.mw) && odd)
                    exp_err = 1'b1;
                pend = '{v: bus.ex_valid, alu: bus.ex_alu_result, sd: bus.ex_store_data,
                         wr: bus.ex_wr, rw: bus.ex_regwrite, mtr: bus.ex_memtoreg,
                         mw: bus.ex_memwrite};
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(posedge clk);
            if (exp_wd_known)
                chk("wb_wd", bus.wb_wd, exp_wd);
            chk("wb_wr", {14'd0, bus.wb_wr}, {14'd0, exp_wr});
            chk("wb_regwrite", {15'd0, bus.wb_regwrite}, {15'd0, exp_rw});
            chk("misalign_err", {15'd0, bus.misalign_err}, {15'd0, exp_err});
`ifdef MEM_WB_FWD_EN
            chk("mem_fwd_regwrite", {15'd0, bus.mem_fwd_regwrite},
                {15'd0, pend.v && pend.rw && (pend.wr != 2'd0)});
            chk("mem_fwd_wr", {14'd0, bus.mem_fwd_wr}, {14'd0, pend.wr});
            chk("mem_fwd_data", bus.mem_fwd_data, pend.alu);
`else
            chk("mem_fwd_regwrite", {15'd0, bus.mem_fwd_regwrite}, 16'd0);
            chk("mem_fwd_wr", {14'd0, bus.mem_fwd_wr}, 16'd0);
            chk("mem_fwd_data", bus.mem_fwd_data, 16'd0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                         input logic [1:0] wr, input logic rw, input logic mtr,
                         input logic mw);
        @(posedge clk);
        #1;
        bus.ex_valid      = v;
        bus.ex_alu_result = alu;
        bus.ex_store_data = sd;
        bus.ex_wr         = wr;
        bus.ex_regwrite   = rw;
        bus.ex_memtoreg   = mtr;
        bus.ex_memwrite   = mw;
    endtask

    task automatic nop();
        drive(1'b0, 16'd0, 16'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "/wb_wd"}, bus.wb_wd, 16'd0);
        chk({tag, "/wb_wr"}, {14'd0, bus.wb_wr}, 16'd0);
        chk({tag, "/wb_regwrite"}, {15'd0, bus.wb_regwrite}, 16'd0);
        chk({tag, "/misalign_err"}, {15'd0, bus.misalign_err}, 16'd0);
        chk({tag, "/fwd_rw"}, {15'd0, bus.mem_fwd_regwrite}, 16'd0);
        chk({tag, "/fwd_wr"}, {14'd0, bus.mem_fwd_wr}, 16'd0);
        chk({tag, "/fwd_data"}, bus.mem_fwd_data, 16'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ex_valid = 0; bus.ex_alu_result = 0; bus.ex_store_data = 0;
        bus.ex_wr = 0; bus.ex_regwrite = 0; bus.ex_memtoreg = 0; bus.ex_memwrite = 0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("por");
        @(posedge clk);
        #3 rst_n = 1'b1;

        // store 0x00AB to 0x0004, then load it into $2
        drive(1, 16'h0004, 16'h00AB, 2'd0, 0, 0, 1);
        drive(1, 16'h0004, 16'h0000, 2'd2, 1, 1, 0);
        nop();
        nop();
        chk("lw/wd", bus.wb_wd, 16'h00AB);
        chk("lw/wr", {14'd0, bus.wb_wr}, 16'd2);
        chk("lw/rw", {15'd0, bus.wb_regwrite}, 16'd1);

        // ALU result 22 into $3, then a bubble carrying the same fields
        drive(1, 16'd22, 16'd0, 2'd3, 1, 0, 0);
        drive(0, 16'd22, 16'd0, 2'd3, 1, 0, 0);
        nop();
        chk("alu/wd", bus.wb_wd, 16'd22);
        chk("alu/wr", {14'd0, bus.wb_wr}, 16'd3);
        chk("alu/rw", {15'd0, bus.wb_regwrite}, 16'd1);
        nop();
        chk("bubble/rw", {15'd0, bus.wb_regwrite}, 16'd0);

        // write to $0 is suppressed
        drive(1, 16'h1234, 16'd0, 2'd0, 1, 0, 0);
        nop();
        nop();
        chk("r0/rw", {15'd0, bus.wb_regwrite}, 16'd0);

        // odd ALU result on a non-memory op does not flag
        drive(1, 16'd7, 16'd0, 2'd1, 1, 0, 0);
        nop();
        nop();
        chk("odd_alu/wd", bus.wb_wd, 16'd7);
        chk("odd_alu/err", {15'd0, bus.misalign_err}, 16'd0);

        // misaligned store is dropped and flags; aligned load sees old data
        drive(1, 16'h0005, 16'hFFFF, 2'd0, 0, 0, 1);
        drive(1, 16'h0004, 16'h0000, 2'd2, 1, 1, 0);
        nop();
        nop();
        chk("mis_sw/wd", bus.wb_wd, 16'h00AB);
        chk("mis_sw/err", {15'd0, bus.misalign_err}, 16'd1);

        // misaligned load: register write suppressed
        drive(1, 16'h0005, 16'h0000, 2'd1, 1, 1, 0);
        nop();
        nop();
        chk("mis_lw/rw", {15'd0, bus.wb_regwrite}, 16'd0);
        repeat (3) nop();
        chk("mis/sticky", {15'd0, bus.misalign_err}, 16'd1);

        // forwarding: ADD $1 = 15 visible one cycle later
        drive(1, 16'd15, 16'd0, 2'd1, 1, 0, 0);
        nop();
`ifdef MEM_WB_FWD_EN
        chk("fwd/rw", {15'd0, bus.mem_fwd_regwrite}, 16'd1);
        chk("fwd/wr", {14'd0, bus.mem_fwd_wr}, 16'd1);
        chk("fwd/data", bus.mem_fwd_data, 16'd15);
`else
        chk("fwd/rw", {15'd0, bus.mem_fwd_regwrite}, 16'd0);
        chk("fwd/wr", {14'd0, bus.mem_fwd_wr}, 16'd0);
        chk("fwd/data", bus.mem_fwd_data, 16'd0);
`endif

        // reset mid-flight: store of 0x5555 to 0x0004 sits in EX/MEM
        drive(1, 16'd22, 16'd0, 2'd3, 1, 0, 0);
        drive(1, 16'h0004, 16'h5555, 2'd0, 0, 0, 1);
        nop();
        chk("pre_rst/wd", bus.wb_wd, 16'd22);
        #1 rst_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        @(posedge clk);
        #3 rst_n = 1'b1;

        // first instruction after reset; memory kept, store dropped
        drive(1, 16'h0004, 16'h0000, 2'd2, 1, 1, 0);
        nop();
        nop();
        chk("post_rst/wd", bus.wb_wd, 16'h00AB);
        chk("post_rst/rw", {15'd0, bus.wb_regwrite}, 16'd1);
        chk("post_rst/err", {15'd0, bus.misalign_err}, 16'd0);

        // wrap: 0x0204 aliases word 2
        drive(1, 16'h0204, 16'h0000, 2'd1, 1, 1, 0);
        nop();
        nop();
        chk("wrap/wd", bus.wb_wd, 16'h00AB);
        nop();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  single stage clock; every register in the block updates on the negative edge, matching the rest of the pipeline.
- rst_n  in  1  reset, asynchronous and active-low.
- ex_valid  in  1  EX stage holds a real instruction; 0 inserts a bubble.
- ex_alu_result  in  16  ALU result; used as the byte address for LW/SW.
- ex_store_data  in  16  rt read data, written to memory by SW.
- ex_wr  in  2  destination register number.
- ex_regwrite  in  1  RegWrite control bit.
- ex_memtoreg  in  1  MemtoReg control bit (1 = load).
- ex_memwrite  in  1  MemWrite control bit (1 = store).
- wb_wd  out  16  write-back data to the register file WD port.
- wb_wr  out  2  write-back register number.
- wb_regwrite  out  1  write-back enable.
- mem_fwd_regwrite  out  1  MEM-stage RegWrite, for forwarding.
- mem_fwd_wr  out  2  MEM-stage destination register.
- mem_fwd_data  out  16  MEM-stage ALU result.
- misalign_err  out  1  sticky misaligned-access flag.

Function
REQ-002 The block SHALL contain two pipeline registers: EX/MEM and MEM/WB.
- Each register holds a valid bit, the data fields and the control bits.
REQ-003 At every negedge, EX/MEM SHALL capture all ex_* inputs.
- A captured ex_valid=0 marks the slot as a bubble.
- A bubble SHALL never write memory or the register file.
REQ-004 Data memory SHALL be 256 x 16-bit words.
- The word index is EX/MEM alu_result[8:1].
- Bits [15:9] are ignored, so addresses wrap modulo 512 bytes.
REQ-005 A store SHALL write memory at the negedge that ends its MEM cycle. All of the following must hold:
- the EX/MEM slot is valid;
- memwrite=1;
- alu_result[0]=0.
REQ-006 Memory read SHALL be combinational from the EX/MEM address.
- A load in the cycle right after a store to the same word SHALL return the newly stored value.
REQ-007 At every negedge, MEM/WB SHALL capture the following:
- data: the memory read data if memtoreg=1, otherwise alu_result;
- destination: wr;
- write enable: regwrite AND valid AND NOT misaligned-load.
REQ-008 wb_wd, wb_wr and wb_regwrite SHALL be driven directly from MEM/WB.
- Latency from ex_* presentation to wb_* is exactly 2 negedges.
- One instruction is accepted per cycle and there are no stalls.
REQ-009 Register 0 is hardwired to zero.
- wb_regwrite SHALL be 0 whenever the captured wr equals 0, whatever regwrite was.
REQ-010 A valid access with alu_result[0]=1 (LW or SW) is misaligned.
- The memory write is suppressed.
- A misaligned load's register write is suppressed.
- misalign_err SHALL become 1 at that negedge and stay 1 until reset.
REQ-011 A non-memory instruction with an odd alu_result SHALL NOT set misalign_err.

Reset
REQ-012 While rst_n=0, independent of clk, the block SHALL hold:
- both valid bits at 0;
- all MEM/WB fields at 0;
- every output at 0, including misalign_err.
REQ-013 Memory contents SHALL NOT be changed by reset.
REQ-014 If reset is asserted mid-operation, any in-flight store not yet committed SHALL be dropped.
REQ-015 The first instruction presented after rst_n rises SHALL reach wb_* 2 negedges later.

Configuration
REQ-016 Forwarding outputs are controlled by the macro MEM_WB_FWD_EN.
- With MEM_WB_FWD_EN defined:
  - mem_fwd_regwrite = EX/MEM regwrite AND valid AND (wr≠0);
  - mem_fwd_wr = EX/MEM wr;
  - mem_fwd_data = EX/MEM alu_result.
- Without MEM_WB_FWD_EN, all three forwarding outputs SHALL be constant 0.
- No other behaviour changes between the two builds.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Reset: drive stimulus, then pull rst_n low between edges -> all outputs 0 immediately, misalign_err=0.
- Store/load: SW addr 0x0004 data 0x00AB, then LW addr 0x0004 wr=2 memtoreg=1 regwrite=1 -> 2 negedges after the LW, wb_wd=0x00AB, wb_wr=2, wb_regwrite=1.
- ALU pass-through: alu_result=22, wr=3, regwrite=1, memtoreg=0 -> wb_wd=22, wb_wr=3, wb_regwrite=1 after 2 negedges; ex_valid=0 on the next cycle -> wb_regwrite=0.
- $0 write: regwrite=1, wr=0, alu_result=0x1234 -> wb_regwrite=0.
- Misaligned: SW addr 0x0005 data 0xFFFF, then LW addr 0x0004 -> misalign_err=1 and stays 1; loaded value unchanged (0x00AB).
- Forwarding, MEM_WB_FWD_EN defined: ADD wr=1 result 15 -> in the next cycle mem_fwd_regwrite=1, mem_fwd_wr=1, mem_fwd_data=15; same stimulus with the macro undefined -> all forwarding outputs 0.
